demux4_8: RTL and testbench



---
 rtl/demux4_8.sv | 84 ++++++++
 tb/tb_demux4_8.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/demux4_8.sv
// demux4_8: registered 1-to-4 valid/ready stream demultiplexer.
// Optional per-channel transfer counters are built when DEMUX4_8_STATS_EN is defined.
`default_nettype none

module demux4_8 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX4_8_STATS_EN
  ,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b,
  output logic [15:0]      cnt_c,
  output logic [15:0]      cnt_d
`endif
);

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [3:0]       load;
  logic [3:0]       xfer;
  logic             accept;

  // Only the addressed channel gates acceptance, so a full channel never stalls the others.
  assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign xfer     = valid_q & out_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) load[in_sel] = 1'b1;
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end else if (load[k]) begin
        // Load wins over drain: a same-edge transfer and reload gives pass-through.
        valid_q[k] <= 1'b1;
        data_q[k]  <= in_data;
      end else if (xfer[k]) begin
        valid_q[k] <= 1'b0;
      end
    end
  end

  assign out_a     = data_q[0];
  assign out_b     = data_q[1];
  assign out_c     = data_q[2];
  assign out_d     = data_q[3];
  assign out_valid = valid_q;

`ifdef DEMUX4_8_STATS_EN
  logic [15:0] cnt_q [4];

  for (genvar k = 0; k < 4; k++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt_q[k] <= '0;
      else if (xfer[k]) cnt_q[k] <= cnt_q[k] + 16'd1;
    end
  end

  assign cnt_a = cnt_q[0];
  assign cnt_b = cnt_q[1];
  assign cnt_c = cnt_q[2];
  assign cnt_d = cnt_q[3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux4_8.sv
// tb_demux4_8: directed self-checking bench for demux4_8.
// Counter checks are compiled in when DEMUX4_8_STATS_EN is defined.
`default_nettype none

module tb_demux4_8;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
`ifdef DEMUX4_8_STATS_EN
  logic [15:0]      cnt_a, cnt_b, cnt_c, cnt_d;
`endif

  int checks = 0;
  int errors = 0;

  demux4_8 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX4_8_STATS_EN
    ,
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c),
    .cnt_d     (cnt_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  function automatic logic [WIDTH-1:0] chan(input int k);
    case (k)
      0:       return out_a;
      1:       return out_b;
      2:       return out_c;
      default: return out_d;
    endcase
  endfunction

  logic [WIDTH-1:0] steer_words [4];
  logic [WIDTH-1:0] w;

  initial begin
    steer_words[0] = 32'h11111111;
    steer_words[1] = 32'h22222222;
    steer_words[2] = 32'h33333333;
    steer_words[3] = 32'h44444444;

    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset while channel a holds a word
    drive(1'b1, 2'd0, 32'hA5A5A5A5);
    tick();
    drive(1'b0, 2'd0, '0);
    check("pre_reset_valid", 64'(out_valid), 64'(4'b0001));
    #1 rst_n = 1'b0;
    #1;
    check("reset_valid", 64'(out_valid), 64'(4'b0000));
    check("reset_out_a", 64'(out_a), 64'(0));
    check("reset_outs_bcd", 64'({out_b, out_c, out_d}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_valid_after", 64'(out_valid), 64'(4'b0000));

    // Steering across all four channels
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), steer_words[i]);
      check($sformatf("steer_ready%0d", i), 64'(in_ready), 64'(1));
      tick();
      check($sformatf("steer_valid%0d", i), 64'(out_valid), 64'(4'b0001 << i));
      check($sformatf("steer_data%0d", i), 64'(chan(i)), 64'(steer_words[i]));
    end
    drive(1'b0, 2'd0, '0);
    tick();
    check("steer_drain", 64'(out_valid), 64'(4'b0000));

    // Backpressure on channel b
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 32'hDEADBEEF);
    check("bp_ready_first", 64'(in_ready), 64'(1));
    tick();
    check("bp_valid_b", 64'(out_valid), 64'(4'b0010));
    drive(1'b1, 2'd1, 32'hCAFEF00D);
    check("bp_ready_blocked", 64'(in_ready), 64'(0));
    tick();
    check("bp_hold_b", 64'(out_b), 64'(32'hDEADBEEF));
    drive(1'b1, 2'd2, 32'h5555AAAA);
    check("bp_ready_c", 64'(in_ready), 64'(1));
    tick();
    check("bp_data_c", 64'(out_c), 64'(32'h5555AAAA));
    check("bp_valid_bc", 64'(out_valid), 64'(4'b0110));
    check("bp_still_b", 64'(out_b), 64'(32'hDEADBEEF));
    out_ready = 4'b1111;
    drive(1'b1, 2'd1, 32'hCAFEF00D);
    check("bp_ready_release", 64'(in_ready), 64'(1));
    tick();
    check("bp_replace_b", 64'(out_b), 64'(32'hCAFEF00D));
    check("bp_valid_after", 64'(out_valid), 64'(4'b0010));
    drive(1'b0, 2'd0, '0);
    tick();
    check("bp_drain", 64'(out_valid), 64'(4'b0000));

    // Pass-through on a full channel a
    drive(1'b1, 2'd0, 32'hA0000000);
    tick();
    for (int i = 0; i < 8; i++) begin
      w = 32'hA0000001 + 32'(i);
      drive(1'b1, 2'd0, w);
      check($sformatf("pt_ready%0d", i), 64'(in_ready), 64'(1));
      tick();
      check($sformatf("pt_data%0d", i), 64'({out_valid[0], out_a}), 64'({1'b1, w}));
    end
    drive(1'b0, 2'd0, '0);
    tick();
    check("pt_drain", 64'(out_valid), 64'(4'b0000));

    // Stability of a stalled channel d
    out_ready = 4'b0111;
    drive(1'b1, 2'd3, 32'hD00DD00D);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'(i % 2 == 0), 2'd3, $urandom);
      check($sformatf("stab_ready%0d", i), 64'(in_ready), 64'(0));
      tick();
      check($sformatf("stab_d%0d", i), 64'({out_valid[3], out_d}), 64'({1'b1, 32'hD00DD00D}));
    end
    drive(1'b0, 2'd0, '0);
    out_ready = 4'b1111;
    tick();
    check("stab_drain", 64'(out_valid), 64'(4'b0000));

`ifdef DEMUX4_8_STATS_EN
    // Counter wrap: 65537 transfers on channel c
    rst_n = 1'b0;
    #1;
    check("cnt_reset", 64'({cnt_a, cnt_b, cnt_c, cnt_d}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 2'd2, 32'h0000C0C0);
    for (int i = 0; i < 65537; i++) tick();
    drive(1'b0, 2'd0, '0);
    check("cnt_c_pre", 64'(cnt_c), 64'(16'd0));
    tick();
    check("cnt_c_wrap", 64'(cnt_c), 64'(16'd1));
    check("cnt_others", 64'({cnt_a, cnt_b, cnt_d}), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
